mem_stage_lsu: RTL and testbench

Parametrised memory pipeline stage with an integrated load/store unit. It sits between EX and WB. It registers ALU results toward write-back and performs byte-serial loads and stores over the 8-bit memory-controller port: little-endian, with sign/zero extension. It stalls upstream while an access is in flight.

---
 rtl/mem_stage_lsu.sv | 182 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: registers ALU results toward WB and runs byte-serial,
// little-endian loads/stores over an 8-bit memory-controller port.
module mem_stage_lsu #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  ex_valid_i,
    input  logic [1:0]            mem_op_i,
    input  logic [1:0]            mem_size_i,
    input  logic                  mem_unsigned_i,
    input  logic [XLEN-1:0]       mem_addr_i,
    input  logic [XLEN-1:0]       mem_wdata_i,
    input  logic [XLEN-1:0]       rd_data_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  rd_enable_i,
    output logic                  mc_req_o,
    output logic                  mc_we_o,
    output logic [ADDR_W-1:0]     mc_addr_o,
    output logic [7:0]            mc_wdata_o,
    input  logic                  mc_ack_i,
    input  logic [7:0]            mc_rdata_i,
    output logic [XLEN-1:0]       rd_data_o,
    output logic [REG_ADDR_W-1:0] rd_addr_o,
    output logic                  rd_enable_o,
    output logic                  stall_o
);
    localparam int unsigned NB = XLEN / 8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [XLEN-1:0]         lbuf_q, lbuf_d;
    logic [XLEN-1:0]         rd_data_q, rd_data_d;
    logic [REG_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic                    mc_req_q, mc_req_d;
    logic                    mc_we_q, mc_we_d;
    logic [ADDR_W-1:0]       mc_addr_q, mc_addr_d;
    logic [7:0]              mc_wdata_q, mc_wdata_d;
    logic                    stall;

    int unsigned             nbytes;
    logic [2:0]              last_idx;
    logic [ADDR_W-1:0]       base_addr;
    logic [XLEN-1:0]         asm_val;
    logic [XLEN-1:0]         ext_val;
    logic                    sign_bit;
    logic [7:0]              wbyte_next;
    logic                    is_mem;

    always_comb begin
        unique case (mem_size_i)
            2'd0:    nbytes = 1;
            2'd1:    nbytes = 2;
            2'd2:    nbytes = 4;
            default: nbytes = (XLEN == 64) ? 8 : 4;
        endcase
        if (nbytes > NB) nbytes = NB;
        last_idx  = 3'(nbytes - 1);
        base_addr = ADDR_W'(mem_addr_i);
        is_mem    = ex_valid_i && (mem_op_i == 2'd1 || mem_op_i == 2'd2);
    end

    // Load buffer with the incoming byte merged in, so the final ack can
    // write back the complete value in the same cycle.
    always_comb begin
        asm_val    = '0;
        ext_val    = '0;
        wbyte_next = '0;
        sign_bit   = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            asm_val[8*i +: 8] = (32'(cnt_q) == i) ? mc_rdata_i : lbuf_q[8*i +: 8];
            if (32'(cnt_q) + 1 == i) wbyte_next = mem_wdata_i[8*i +: 8];
        end
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i == 8 * nbytes - 1) sign_bit = asm_val[i];
        end
        for (int unsigned i = 0; i < XLEN; i++) begin
            ext_val[i] = (i < 8 * nbytes) ? asm_val[i] : (sign_bit & ~mem_unsigned_i);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lbuf_d     = lbuf_q;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = rd_en_q;
        mc_req_d   = mc_req_q;
        mc_we_d    = mc_we_q;
        mc_addr_d  = mc_addr_q;
        mc_wdata_d = mc_wdata_q;
        stall      = 1'b1;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    stall   = 1'b0;
                    rd_en_d = 1'b0;
                    if (is_mem) begin
                        stall      = 1'b1;
                        state_d    = BUSY;
                        cnt_d      = '0;
                        mc_req_d   = 1'b1;
                        mc_we_d    = (mem_op_i == 2'd2);
                        mc_addr_d  = base_addr;
                        mc_wdata_d = mem_wdata_i[7:0];
                    end else if (ex_valid_i) begin
                        rd_data_d = rd_data_i;
                        rd_addr_d = rd_addr_i;
                        rd_en_d   = rd_enable_i;
                    end
                end
                BUSY: begin
                    rd_en_d = 1'b0;
                    if (mc_ack_i) begin
                        lbuf_d = asm_val;
                        if (cnt_q < last_idx) begin
                            cnt_d      = cnt_q + 3'd1;
                            mc_addr_d  = base_addr + ADDR_W'(cnt_q + 3'd1);
                            mc_wdata_d = wbyte_next;
                        end else begin
                            stall    = 1'b0;
                            state_d  = IDLE;
                            cnt_d    = '0;
                            mc_req_d = 1'b0;
                            mc_we_d  = 1'b0;
                            if (!mc_we_q) begin
                                rd_data_d = ext_val;
                                rd_addr_d = rd_addr_i;
                                rd_en_d   = rd_enable_i;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (!rst) stall = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lbuf_q     <= '0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            mc_req_q   <= 1'b0;
            mc_we_q    <= 1'b0;
            mc_addr_q  <= '0;
            mc_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lbuf_q     <= lbuf_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            mc_req_q   <= mc_req_d;
            mc_we_q    <= mc_we_d;
            mc_addr_q  <= mc_addr_d;
            mc_wdata_q <= mc_wdata_d;
        end
    end

    assign mc_req_o    = mc_req_q;
    assign mc_we_o     = mc_we_q;
    assign mc_addr_o   = mc_addr_q;
    assign mc_wdata_o  = mc_wdata_q;
    assign rd_data_o   = rd_data_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_enable_o = rd_en_q;
    assign stall_o     = stall;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed + randomized bench for mem_stage_lsu against a byte-addressed memory model.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst, rdy, ex_valid_i, mem_unsigned_i, rd_enable_i, mc_ack_i;
    logic [1:0]  mem_op_i, mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i, rd_data_i;
    logic [4:0]  rd_addr_i;
    logic [7:0]  mc_rdata_i;
    logic        mc_req_o, mc_we_o, rd_enable_o, stall_o;
    logic [31:0] mc_addr_o, rd_data_o;
    logic [7:0]  mc_wdata_o;
    logic [4:0]  rd_addr_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] e_data;
    logic [4:0]  e_addr;
    logic        e_en;
    logic [31:0] last_addr;
    logic [7:0]  last_wbyte;
    logic [7:0]  mem [logic [31:0]];

    mem_stage_lsu #(.XLEN(32), .REG_ADDR_W(5), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .ex_valid_i(ex_valid_i),
        .mem_op_i(mem_op_i), .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .rd_data_i(rd_data_i),
        .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i), .mc_req_o(mc_req_o),
        .mc_we_o(mc_we_o), .mc_addr_o(mc_addr_o), .mc_wdata_o(mc_wdata_o),
        .mc_ack_i(mc_ack_i), .mc_rdata_i(mc_rdata_i), .rd_data_o(rd_data_o),
        .rd_addr_o(rd_addr_o), .rd_enable_o(rd_enable_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [31:0] load_ref(input logic [31:0] a, input int n, input logic uns);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(mem_rd(a + 32'(i))) << (8 * i));
        if (!uns && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v[31:0];
    endfunction

    task automatic check_wb();
        chk("wb_data", 64'(rd_data_o), 64'(e_data));
        chk("wb_addr", 64'(rd_addr_o), 64'(e_addr));
        chk("wb_en", 64'(rd_enable_o), 64'(e_en));
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_stall"}, 64'(stall_o), 64'd0);
        chk({tag, "_req"}, 64'(mc_req_o), 64'd0);
        chk({tag, "_we"}, 64'(mc_we_o), 64'd0);
        chk({tag, "_addr_hold"}, 64'(mc_addr_o), 64'(last_addr));
        chk({tag, "_wdata_hold"}, 64'(mc_wdata_o), 64'(last_wbyte));
    endtask

    task automatic bubble();
        @(posedge clk); #1;
        check_wb();
        rdy = 1'b1; ex_valid_i = 1'b0;
        mem_op_i = 2'($urandom); mem_size_i = 2'($urandom);
        mem_addr_i = $urandom; rd_data_i = $urandom; rd_enable_i = 1'b1;
        mc_ack_i = 1'($urandom); mc_rdata_i = 8'($urandom);
        #1;
        idle_chk("bubble");
        e_en = 1'b0;
    endtask

    task automatic alu(input logic [31:0] d, input logic [4:0] ra, input logic re, input logic [1:0] op);
        @(posedge clk); #1;
        check_wb();
        rdy = 1'b1; ex_valid_i = 1'b1; mem_op_i = op; mem_size_i = 2'($urandom);
        mem_addr_i = $urandom; rd_data_i = d; rd_addr_i = ra; rd_enable_i = re;
        mc_ack_i = 1'($urandom); mc_rdata_i = 8'($urandom);
        #1;
        idle_chk("alu");
        e_data = d; e_addr = ra; e_en = re;
    endtask

    task automatic mem_access(input logic [1:0] op, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] ra, input logic re, input int wait_n,
                              input int freeze_byte);
        int n;
        logic [31:0] a, ldv, sh;
        logic [7:0] wb;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        ldv = load_ref(addr, n, uns);
        @(posedge clk); #1;
        check_wb();
        rdy = 1'b1; ex_valid_i = 1'b1; mem_op_i = op; mem_size_i = size; mem_unsigned_i = uns;
        mem_addr_i = addr; mem_wdata_i = wdata; rd_data_i = $urandom;
        rd_addr_i = ra; rd_enable_i = re; mc_ack_i = 1'($urandom); mc_rdata_i = 8'($urandom);
        #1;
        chk("acc_stall", 64'(stall_o), 64'd1);
        chk("acc_req", 64'(mc_req_o), 64'd0);
        e_en = 1'b0;
        for (int bi = 0; bi < n; bi++) begin
            a = addr + 32'(bi);
            sh = wdata >> (8 * bi);
            wb = sh[7:0];
            if (bi == freeze_byte) begin
                for (int f = 0; f < 3; f++) begin
                    @(posedge clk); #1;
                    check_wb();
                    rdy = 1'b0; mc_ack_i = 1'b1; mc_rdata_i = 8'($urandom);
                    #1;
                    chk("frz_stall", 64'(stall_o), 64'd1);
                    chk("frz_req", 64'(mc_req_o), 64'd1);
                    chk("frz_addr", 64'(mc_addr_o), 64'(a));
                end
            end
            for (int w = 0; w <= wait_n; w++) begin
                @(posedge clk); #1;
                check_wb();
                rdy = 1'b1;
                mc_ack_i = (w == wait_n);
                mc_rdata_i = (w == wait_n && op == 2'd1) ? mem_rd(a) : 8'($urandom);
                #1;
                chk("busy_req", 64'(mc_req_o), 64'd1);
                chk("busy_we", 64'(mc_we_o), 64'(op == 2'd2));
                chk("busy_addr", 64'(mc_addr_o), 64'(a));
                chk("busy_wdata", 64'(mc_wdata_o), 64'(wb));
                chk("busy_stall", 64'(stall_o), 64'(!(w == wait_n && bi == n - 1)));
                last_addr = a;
                last_wbyte = wb;
                e_en = 1'b0;
                if (w == wait_n) begin
                    if (op == 2'd2) mem[a] = wb;
                    if (bi == n - 1 && op == 2'd1) begin
                        e_data = ldv; e_addr = ra; e_en = re;
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; ex_valid_i = 1'b0; mem_op_i = '0; mem_size_i = '0;
        mem_unsigned_i = 1'b0; mem_addr_i = '0; mem_wdata_i = '0; rd_data_i = '0;
        rd_addr_i = '0; rd_enable_i = 1'b0; mc_ack_i = 1'b0; mc_rdata_i = '0;
        e_data = '0; e_addr = '0; e_en = 1'b0; last_addr = '0; last_wbyte = '0;
        mem[32'h1000] = 8'h78; mem[32'h1001] = 8'h56; mem[32'h1002] = 8'h34; mem[32'h1003] = 8'h12;
        mem[32'h5000] = 8'h80;

        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", 64'(stall_o), 64'd0);
        check_wb();
        idle_chk("rst");
        #2 rst = 1'b1;

        alu(32'hDEADBEEF, 5'd7, 1'b1, 2'd0);
        bubble();

        mem_access(2'd1, 2'd2, 1'b0, 32'h1000, $urandom, 5'd3, 1'b1, 0, -1);
        bubble();
        chk("lw_value", 64'(rd_data_o), 64'h12345678);

        mem_access(2'd1, 2'd0, 1'b0, 32'h5000, $urandom, 5'd4, 1'b1, 0, -1);
        bubble();
        chk("lb_value", 64'(rd_data_o), 64'hFFFFFF80);
        mem_access(2'd1, 2'd0, 1'b1, 32'h5000, $urandom, 5'd4, 1'b1, 0, -1);
        bubble();
        chk("lbu_value", 64'(rd_data_o), 64'h00000080);

        mem_access(2'd2, 2'd1, 1'b0, 32'h2001, 32'h0000A1B2, 5'd5, 1'b1, 2, -1);
        bubble();
        mem_access(2'd1, 2'd1, 1'b1, 32'h2001, $urandom, 5'd6, 1'b1, 1, -1);
        bubble();
        chk("sh_readback", 64'(rd_data_o), 64'h0000A1B2);

        mem_access(2'd1, 2'd2, 1'b0, 32'hFFFFFFFF, $urandom, 5'd8, 1'b1, 0, -1);
        bubble();

        mem_access(2'd1, 2'd2, 1'b0, 32'h1000, $urandom, 5'd10, 1'b1, 0, 2);
        alu(32'h0BADF00D, 5'd11, 1'b1, 2'd3);
        chk("frz_lw_value", 64'(rd_data_o), 64'h12345678);

        // LW interrupted by reset after its second byte
        @(posedge clk); #1;
        check_wb();
        ex_valid_i = 1'b1; mem_op_i = 2'd1; mem_size_i = 2'd2; mem_addr_i = 32'h4000;
        rd_addr_i = 5'd12; rd_enable_i = 1'b1; mc_ack_i = 1'b0;
        #1;
        chk("rstlw_stall", 64'(stall_o), 64'd1);
        e_en = 1'b0;
        for (int bi = 0; bi < 2; bi++) begin
            @(posedge clk); #1;
            check_wb();
            mc_ack_i = 1'b1; mc_rdata_i = mem_rd(32'h4000 + 32'(bi));
            #1;
            chk("rstlw_addr", 64'(mc_addr_o), 64'h4000 + 64'(bi));
        end
        @(posedge clk); #1;
        check_wb();
        mc_ack_i = 1'b0;
        #1;
        chk("rstlw_req_before", 64'(mc_req_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("rstlw_req", 64'(mc_req_o), 64'd0);
        chk("rstlw_en", 64'(rd_enable_o), 64'd0);
        chk("rstlw_stall0", 64'(stall_o), 64'd0);
        e_data = '0; e_addr = '0; e_en = 1'b0; last_addr = '0; last_wbyte = '0;
        ex_valid_i = 1'b0;
        @(posedge clk); #1;
        check_wb();
        rst = 1'b1;
        alu(32'hCAFEF00D, 5'd9, 1'b1, 2'd0);
        bubble();

        for (int it = 0; it < 60; it++) begin
            int kind;
            logic [31:0] ad;
            kind = int'($urandom % 4);
            ad = (($urandom % 4) == 0) ? $urandom : 32'h3000 + ($urandom % 48);
            case (kind)
                0: alu($urandom, 5'($urandom), 1'($urandom), (($urandom % 2) == 0) ? 2'd0 : 2'd3);
                1: bubble();
                2: mem_access(2'd1, 2'($urandom), 1'($urandom), ad, $urandom, 5'($urandom),
                              1'($urandom), int'($urandom % 3), int'($urandom % 6));
                default: mem_access(2'd2, 2'($urandom), 1'($urandom), ad, $urandom, 5'($urandom),
                                    1'($urandom), int'($urandom % 3), int'($urandom % 6));
            endcase
        end
        bubble();
        bubble();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
